// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_pkg;

    // Converter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int         DIGIT_W       = 4;
    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake bundle between a requester and the BCD converter.
// Latency: n/a (wiring only).
// Backpressure: requester must watch busy; start is ignored while busy is high.
// Ports: start/bin from requester; busy/done/bcd/overflow from converter.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    // Requester side
    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    // Converter side
    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
// Latency: purely combinational.
// Backpressure: none.
// Ports: digit_i (4-bit scratch digit), digit_o (corrected digit).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [DIGIT_W-1:0] digit_o
);

    // Scratch digits never exceed 9, so +3 always fits in 4 bits.
    assign digit_o = (digit_i >= ADJ_THRESHOLD) ? (digit_i + ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary to packed BCD converter, one input bit per clock.
// Latency: done pulses for the cycle after the WIDTH-th edge following the accepting edge.
// Backpressure: start is ignored while busy; accepted again in IDLE or the DONE cycle.
// Ports: clk, reset (async, active-high); bus = slave side of bin_to_bcd_seq_if
//        (start/bin in; busy/done/bcd/overflow out). bcd holds its value between runs.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    bin_to_bcd_seq_if.slave     bus
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic              ovf_scr_q, ovf_scr_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    // Corrected scratch digits, all in parallel
    logic [BW-1:0]     adj;
    // Values after the corrected shift of {scratch, shiftreg}
    logic [BW-1:0]     scratch_sh;
    logic [WIDTH-1:0]  shift_sh;
    logic              ovf_sh;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_o (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // A bit leaving the top digit represents a lost multiple of 10^DIGITS;
    // the remaining digits still hold the value modulo 10^DIGITS.
    always_comb begin
        scratch_sh = {adj[BW-2:0], shift_q[WIDTH-1]};
        shift_sh   = shift_q << 1;
        ovf_sh     = ovf_scr_q | adj[BW-1];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        ovf_scr_d = ovf_scr_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                shift_d   = shift_sh;
                scratch_d = scratch_sh;
                ovf_scr_d = ovf_sh;
                cnt_d     = cnt_q - CW'(1);
                // Output registers only move on the final shift so the
                // displays never see a partial result.
                if (cnt_q == CW'(1)) begin
                    bcd_d   = scratch_sh;
                    ovf_d   = ovf_sh;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            ovf_scr_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            ovf_scr_q <= ovf_scr_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    // Registered state decodes, glitch-free
    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 3-digit and 2-digit instances, 8-bit input.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin_to_bcd_seq;

    logic clk;
    logic reset;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) a_if ();
    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) b_if ();

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ref_bcd(input int v, input int d);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Drives one start on instance a (sel=0) or b (sel=1), then waits for done.
    // lat = edges after the accepting edge until done is seen; nbusy = cycles
    // with busy high seen before done.
    task automatic convert(input bit sel, input logic [7:0] v, output int lat, output int nbusy);
        bit seen;
        if (sel) begin b_if.start = 1'b1; b_if.bin = v; end
        else     begin a_if.start = 1'b1; a_if.bin = v; end
        tick;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
        lat   = 0;
        nbusy = 0;
        seen  = 1'b0;
        while (!seen && lat < 20) begin
            tick;
            lat++;
            seen = sel ? b_if.done : a_if.done;
            if (!seen && (sel ? b_if.busy : a_if.busy)) nbusy++;
        end
        if (!seen) check("done_timeout", 32'(seen), 32'd1);
    endtask

    int lat, nbusy, ndone;
    logic [11:0] prev_bcd;
    logic        digit_bad;

    initial begin
        reset      = 1'b1;
        a_if.start = 1'b0;
        a_if.bin   = '0;
        b_if.start = 1'b0;
        b_if.bin   = '0;
        #12;
        // Reset state
        check("rst_busy", 32'(a_if.busy), 32'd0);
        check("rst_done", 32'(a_if.done), 32'd0);
        check("rst_bcd",  32'(a_if.bcd), 32'd0);
        check("rst_ovf",  32'(a_if.overflow), 32'd0);
        reset = 1'b0;
        tick;

        // 1: 255
        convert(1'b0, 8'd255, lat, nbusy);
        check("t1_lat",   32'(lat), 32'd8);
        check("t1_busy",  32'(nbusy), 32'd7);
        check("t1_bcd",   32'(a_if.bcd), 32'h255);
        check("t1_ovf",   32'(a_if.overflow), 32'd0);
        check("t1_busy_at_done", 32'(a_if.busy), 32'd0);
        tick;
        check("t1_done_width", 32'(a_if.done), 32'd0);

        // 2: 0 then 9 back-to-back, second start during the DONE cycle
        convert(1'b0, 8'd0, lat, nbusy);
        check("t2a_bcd", 32'(a_if.bcd), 32'h000);
        a_if.start = 1'b1;
        a_if.bin   = 8'd9;
        tick;
        a_if.start = 1'b0;
        check("t2_done_width", 32'(a_if.done), 32'd0);
        check("t2_busy_again", 32'(a_if.busy), 32'd1);
        ndone = 1;
        while (!a_if.done && ndone < 20) begin
            tick;
            ndone++;
        end
        check("t2_gap", 32'(ndone), 32'd9);
        check("t2b_bcd", 32'(a_if.bcd), 32'h009);

        // 3: two-digit instance overflow
        convert(1'b1, 8'd100, lat, nbusy);
        check("t3_100_bcd", 32'(b_if.bcd), 32'h00);
        check("t3_100_ovf", 32'(b_if.overflow), 32'd1);
        convert(1'b1, 8'd123, lat, nbusy);
        check("t3_123_bcd", 32'(b_if.bcd), 32'h23);
        check("t3_123_ovf", 32'(b_if.overflow), 32'd1);
        convert(1'b1, 8'd99, lat, nbusy);
        check("t3_99_bcd", 32'(b_if.bcd), 32'h99);
        check("t3_99_ovf", 32'(b_if.overflow), 32'd0);

        // 4: start while busy is ignored; bcd stable until completion
        tick;
        prev_bcd   = a_if.bcd;
        a_if.start = 1'b1;
        a_if.bin   = 8'd42;
        tick;
        a_if.start = 1'b0;
        tick;
        tick;
        a_if.start = 1'b1;
        a_if.bin   = 8'd200;
        tick;
        a_if.start = 1'b0;
        check("t4_hold_bcd", 32'(a_if.bcd), 32'(prev_bcd));
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (a_if.done) begin
                ndone++;
                check("t4_bcd", 32'(a_if.bcd), 32'h042);
            end
        end
        check("t4_ndone", 32'(ndone), 32'd1);

        // 5: async reset mid-conversion
        a_if.start = 1'b1;
        a_if.bin   = 8'd77;
        tick;
        a_if.start = 1'b0;
        tick;
        tick;
        #2;
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(a_if.busy), 32'd0);
        check("t5_done", 32'(a_if.done), 32'd0);
        check("t5_bcd",  32'(a_if.bcd), 32'd0);
        check("t5_ovf",  32'(b_if.overflow), 32'd0);
        tick;
        tick;
        #3;
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (a_if.done) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);
        convert(1'b0, 8'd137, lat, nbusy);
        check("t5_137_bcd", 32'(a_if.bcd), 32'h137);

        // 6: exhaustive three-digit sweep
        for (int v = 0; v < 256; v++) begin
            convert(1'b0, 8'(v), lat, nbusy);
            digit_bad = 1'b0;
            for (int k = 0; k < 3; k++)
                if (a_if.bcd[4*k +: 4] > 4'd9) digit_bad = 1'b1;
            check($sformatf("t6_bcd_%0d", v), 32'(a_if.bcd), 32'(ref_bcd(v, 3)));
            check($sformatf("t6_ovf_%0d", v), 32'(a_if.overflow), 32'd0);
            check($sformatf("t6_dig_%0d", v), 32'(digit_bad), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
